// File: rtl/rom_load_sequencer.sv
// rom_load_sequencer
//
// Accepts the HPS ioctl byte stream for ROM downloads (index 0). It packs
// even/odd bytes into 16-bit words and tags each word with one of four ROM
// regions. Words are queued in a small FIFO that drains over a req/ack
// memory write port. ioctl_wait throttles the HPS. done pulses once after
// the last word of a download has been accepted by memory.
//
// Optional feature (macro ROM_LOAD_CHECKSUM_EN):
//   Defined   : checksum holds a 16-bit wrapping sum of the accepted bytes.
//               The sum is cleared when a new download starts.
//   Undefined : checksum is tied to zero.
//
// Ports:
//   clk_sys, reset       clock and synchronous active-high reset
//   ioctl_download       download active
//   ioctl_index          download index; only index 0 is processed
//   ioctl_wr             one-cycle byte strobe
//   ioctl_addr           byte address
//   ioctl_dout           byte data
//   ioctl_wait           stall request to the HPS
//   mem_req/mem_ack      write handshake. mem_req is a level that stays high
//                        while a word is queued. mem_region/mem_addr/mem_data
//                        hold steady while mem_req is high. A one-cycle
//                        mem_ack with mem_req high retires the head word, and
//                        the next word appears the following cycle. A mem_ack
//                        while mem_req is low has no effect.
//   mem_region/addr/data head word: region, region-relative word address,
//                        {odd byte, even byte}
//   busy                 download in progress or words still queued
//   done                 one-cycle pulse when a load has fully drained
//   checksum             byte sum (see optional feature)
//   fsm_state            current sequencer state, for observation

module rom_load_sequencer #(
  parameter int                ADDR_W     = 25,
  parameter logic [ADDR_W-1:0] R1_BASE    = 25'h008000,
  parameter logic [ADDR_W-1:0] R2_BASE    = 25'h010000,
  parameter logic [ADDR_W-1:0] R3_BASE    = 25'h020000,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [1:0]        mem_region,
  output logic [ADDR_W-2:0] mem_addr,
  output logic [15:0]       mem_data,
  output logic              busy,
  output logic              done,
  output logic [15:0]       checksum,
  output logic [2:0]        fsm_state
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FLUSH = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  typedef struct packed {
    logic [1:0]        region;
    logic [ADDR_W-2:0] addr;
    logic [15:0]       data;
  } entry_t;

  state_t            state_q;
  logic [ADDR_W-2:0] slot_waddr;
  logic [7:0]        slot_lo;
  logic [7:0]        slot_hi;
  logic [1:0]        slot_vld;    // bit 0 = low byte present, bit 1 = high byte present
  entry_t            fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;

  logic              index_ok;
  logic              start;
  logic              accept;
  logic [ADDR_W-2:0] byte_waddr;
  logic              byte_odd;
  logic [1:0]        cur_vld;
  logic [ADDR_W-2:0] nxt_waddr;
  logic [7:0]        nxt_lo;
  logic [7:0]        nxt_hi;
  logic [1:0]        nxt_vld;
  logic              push;
  logic              pop;
  logic [ADDR_W-2:0] push_waddr;
  logic [7:0]        push_lo;
  logic [7:0]        push_hi;
  logic [ADDR_W-1:0] push_byte_addr;
  entry_t            push_entry;

  assign index_ok   = (ioctl_index == 8'd0);
  // Start is level sensitive. A download that rose while a previous load was
  // still draining is therefore picked up as soon as IDLE is reached.
  assign start      = (state_q == S_IDLE) & ioctl_download & index_ok;
  assign accept     = ioctl_wr & ioctl_download & index_ok &
                      ((state_q == S_LOAD) | start);
  assign byte_waddr = ioctl_addr[ADDR_W-1:1];
  assign byte_odd   = ioctl_addr[0];
  assign cur_vld    = start ? 2'b00 : slot_vld;

  // Pending-slot update and FIFO push selection. At most one push can result
  // from a strobe: a word-address change evicts the old slot, and the new
  // single byte cannot complete a word on its own.
  always_comb begin
    nxt_waddr  = slot_waddr;
    nxt_lo     = slot_lo;
    nxt_hi     = slot_hi;
    nxt_vld    = cur_vld;
    push       = 1'b0;
    push_waddr = slot_waddr;
    push_lo    = slot_vld[0] ? slot_lo : 8'hFF;
    push_hi    = slot_vld[1] ? slot_hi : 8'hFF;
    if (accept) begin
      if ((cur_vld != 2'b00) && (byte_waddr != slot_waddr)) begin
        push      = 1'b1;
        nxt_waddr = byte_waddr;
        nxt_lo    = ioctl_dout;
        nxt_hi    = ioctl_dout;
        nxt_vld   = byte_odd ? 2'b10 : 2'b01;
      end else begin
        nxt_waddr = byte_waddr;
        if (byte_odd) begin
          nxt_hi     = ioctl_dout;
          nxt_vld[1] = 1'b1;
          if (cur_vld[0]) begin
            push       = 1'b1;
            push_waddr = byte_waddr;
            push_lo    = slot_lo;
            push_hi    = ioctl_dout;
            nxt_vld    = 2'b00;
          end
        end else begin
          nxt_lo     = ioctl_dout;
          nxt_vld[0] = 1'b1;
        end
      end
    end else if ((state_q == S_FLUSH) && (slot_vld != 2'b00)) begin
      push    = 1'b1;
      nxt_vld = 2'b00;
    end
  end

  // Region decode. The region bases are even, so the relative word address
  // is the word address minus the base's word address.
  assign push_byte_addr = {push_waddr, 1'b0};

  always_comb begin
    push_entry.data = {push_hi, push_lo};
    if (push_byte_addr < R1_BASE) begin
      push_entry.region = 2'd0;
      push_entry.addr   = push_waddr;
    end else if (push_byte_addr < R2_BASE) begin
      push_entry.region = 2'd1;
      push_entry.addr   = push_waddr - R1_BASE[ADDR_W-1:1];
    end else if (push_byte_addr < R3_BASE) begin
      push_entry.region = 2'd2;
      push_entry.addr   = push_waddr - R2_BASE[ADDR_W-1:1];
    end else begin
      push_entry.region = 2'd3;
      push_entry.addr   = push_waddr - R3_BASE[ADDR_W-1:1];
    end
  end

  assign mem_req    = (count != '0);
  assign pop        = mem_ack & mem_req;
  assign mem_region = fifo_mem[rd_ptr].region;
  assign mem_addr   = fifo_mem[rd_ptr].addr;
  assign mem_data   = fifo_mem[rd_ptr].data;
  assign busy       = (state_q != S_IDLE) | mem_req;
  assign done       = (state_q == S_DONE);
  assign fsm_state  = state_q;

  // Leaving FIFO_DEPTH-2 as the threshold keeps headroom for two pushes that
  // land after the HPS has already been told to wait.
  assign ioctl_wait = (count >= CNT_W'(FIFO_DEPTH - 2)) |
                      (state_q == S_FLUSH) |
                      (((state_q == S_DRAIN) | (state_q == S_DONE)) &
                       ioctl_download & index_ok);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= S_IDLE;
      slot_waddr <= '0;
      slot_lo    <= '0;
      slot_hi    <= '0;
      slot_vld   <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      slot_waddr <= nxt_waddr;
      slot_lo    <= nxt_lo;
      slot_hi    <= nxt_hi;
      slot_vld   <= nxt_vld;
      if (push) begin
        fifo_mem[wr_ptr] <= push_entry;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);

      case (state_q)
        S_IDLE:  if (start) state_q <= S_LOAD;
        S_LOAD:  if (!ioctl_download) state_q <= S_FLUSH;
        S_FLUSH: state_q <= S_DRAIN;
        S_DRAIN: if (count == '0) state_q <= S_DONE;
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // The wait threshold guarantees headroom, so a push into a full FIFO
  // without a simultaneous pop points at a broken throttle.
  always_ff @(posedge clk_sys) begin
    if (!reset) assert (!(push && !pop && (count == CNT_W'(FIFO_DEPTH))));
  end

`ifdef ROM_LOAD_CHECKSUM_EN
  logic [15:0] sum_q;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sum_q <= '0;
    end else if (start) begin
      sum_q <= accept ? {8'h00, ioctl_dout} : 16'h0000;
    end else if (accept) begin
      sum_q <= sum_q + {8'h00, ioctl_dout};
    end
  end

  assign checksum = sum_q;
`else
  assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_rom_load_sequencer.sv
module tb_rom_load_sequencer;

  localparam int          ADDR_W = 25;
  localparam logic [24:0] R1     = 25'h008000;
  localparam logic [24:0] R2     = 25'h010000;
  localparam logic [24:0] R3     = 25'h020000;

  localparam int ACK_NEXT  = 0;
  localparam int ACK_RAND  = 1;
  localparam int ACK_STALL = 2;
  localparam int ACK_LATE  = 3;

  logic        clk_sys;
  logic        reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        mem_req;
  logic        mem_ack;
  logic [1:0]  mem_region;
  logic [23:0] mem_addr;
  logic [15:0] mem_data;
  logic        busy;
  logic        done;
  logic [15:0] checksum;
  logic [2:0]  fsm_state;

  rom_load_sequencer dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .ioctl_download(ioctl_download),
    .ioctl_index   (ioctl_index),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .ioctl_wait    (ioctl_wait),
    .mem_req       (mem_req),
    .mem_ack       (mem_ack),
    .mem_region    (mem_region),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .busy          (busy),
    .done          (done),
    .checksum      (checksum),
    .fsm_state     (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  // ---------------- scoreboard / model state ----------------
  typedef logic [41:0] wr_t;  // {region[1:0], addr[23:0], data[15:0]}

  wr_t         exp_q[$];
  wr_t         got_q[$];
  logic [1:0]  m_vld;
  logic [23:0] m_waddr;
  logic [7:0]  m_lo;
  logic [7:0]  m_hi;
  logic [15:0] m_sum;
  int          total;
  int          bad;
  int          done_seen;
  int          ack_mode;
  bit          chk_wait;
  bit          wait_seen;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_checksum();
`ifdef ROM_LOAD_CHECKSUM_EN
    return m_sum;
`else
    return 16'h0000;
`endif
  endfunction

  // Expected write for a word: region found by comparing the byte address to
  // the bases, region-relative word offset by plain arithmetic.
  function automatic wr_t make_wr(input logic [23:0] w, input logic [1:0] v,
                                  input logic [7:0] lo, input logic [7:0] hi);
    longint bases[4];
    longint a;
    longint rel;
    int     r;
    logic [7:0] dlo;
    logic [7:0] dhi;
    bases[0] = 0;
    bases[1] = longint'(R1);
    bases[2] = longint'(R2);
    bases[3] = longint'(R3);
    a = longint'(w) * 2;
    r = 0;
    for (int i = 1; i < 4; i++) if (a >= bases[i]) r = i;
    rel = (a - bases[r]) / 2;
    dlo = v[0] ? lo : 8'hFF;
    dhi = v[1] ? hi : 8'hFF;
    return {2'(r), 24'(rel), dhi, dlo};
  endfunction

  task automatic model_byte(input logic [24:0] addr, input logic [7:0] data);
    logic [23:0] w;
    w = addr[24:1];
    m_sum = m_sum + {8'h00, data};
    if (m_vld != 2'b00 && w != m_waddr) begin
      exp_q.push_back(make_wr(m_waddr, m_vld, m_lo, m_hi));
      m_vld = 2'b00;
    end
    m_waddr = w;
    if (addr[0]) begin
      m_hi = data;
      m_vld[1] = 1'b1;
      if (m_vld[0]) begin
        exp_q.push_back(make_wr(m_waddr, 2'b11, m_lo, m_hi));
        m_vld = 2'b00;
      end
    end else begin
      m_lo = data;
      m_vld[0] = 1'b1;
    end
  endtask

  task automatic model_flush();
    if (m_vld != 2'b00) exp_q.push_back(make_wr(m_waddr, m_vld, m_lo, m_hi));
    m_vld = 2'b00;
  endtask

  // ---------------- per-cycle compare ----------------
  initial begin
    logic        prev_req;
    logic [41:0] prev_head;
    prev_req  = 1'b0;
    prev_head = '0;
    forever begin
      @(posedge clk_sys);
      #1;
      check("mem_req", 64'(mem_req), 64'(exp_q.size() != 0));
      check("checksum", 64'(checksum), 64'(exp_checksum()));
      if (chk_wait) begin
        check("ioctl_wait", 64'(ioctl_wait), 64'(exp_q.size() >= 2));
        if (ioctl_wait) wait_seen = 1'b1;
      end
      if (mem_req && prev_req && !mem_ack)
        check("head_stable", 64'({mem_region, mem_addr, mem_data}), 64'(prev_head));
      if (done) begin
        done_seen++;
        check("done_drained", 64'(exp_q.size()), 64'd0);
      end
      prev_req  = mem_req;
      prev_head = {mem_region, mem_addr, mem_data};
    end
  end

  // ---------------- memory-side ack driver ----------------
  initial begin
    mem_ack = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (ack_mode == ACK_LATE) begin
        mem_ack  = 1'b1;
        ack_mode = ACK_STALL;
      end else if (mem_ack || ack_mode == ACK_STALL) begin
        mem_ack = 1'b0;
      end else if (mem_req && (ack_mode == ACK_NEXT || $urandom_range(0, 2) == 0)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 64'({mem_region, mem_addr, mem_data}), 64'd0);
        end else begin
          check("write", 64'({mem_region, mem_addr, mem_data}), 64'(exp_q.pop_front()));
        end
        got_q.push_back({mem_region, mem_addr, mem_data});
        mem_ack = 1'b1;
      end
    end
  end

  // ---------------- HPS-side driver tasks ----------------
  task automatic send_byte(input logic [24:0] addr, input logic [7:0] data, input bit force_it);
    int n;
    n = 0;
    @(negedge clk_sys);
    while (ioctl_wait && !force_it && n < 300) begin
      @(negedge clk_sys);
      n++;
    end
    if (n >= 300) check("wait_timeout", 64'(ioctl_wait), 64'd0);
    ioctl_wr   = 1'b1;
    ioctl_addr = addr;
    ioctl_dout = data;
    if (ioctl_download && ioctl_index == 8'd0) model_byte(addr, data);
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
  endtask

  task automatic start_download();
    @(negedge clk_sys);
    ioctl_download = 1'b1;
    ioctl_index    = 8'd0;
    m_vld          = 2'b00;
    m_sum          = 16'h0000;
    chk_wait       = 1'b1;
    got_q.delete();
  endtask

  task automatic end_download();
    int d0;
    int n;
    @(negedge clk_sys);
    check("busy_in_load", 64'(busy), 64'd1);
    ioctl_download = 1'b0;
    chk_wait       = 1'b0;
    @(negedge clk_sys);
    model_flush();
    d0 = done_seen;
    n  = 0;
    while (busy && n < 1000) begin
      @(negedge clk_sys);
      n++;
    end
    check("drain_in_time", 64'(busy), 64'd0);
    check("done_once", 64'(done_seen - d0), 64'd1);
    check("all_written", 64'(exp_q.size()), 64'd0);
  endtask

  function automatic logic [24:0] pick_addr();
    logic [24:0] bases[5];
    bases[0] = 25'h0;
    bases[1] = R1 - 25'd4;
    bases[2] = R2 - 25'd4;
    bases[3] = R3 - 25'd4;
    bases[4] = 25'h1FFFFF8;
    return bases[$urandom_range(0, 4)] + 25'($urandom_range(0, 3));
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int d0;
    logic [24:0] a;

    total = 0; bad = 0; done_seen = 0; ack_mode = ACK_NEXT;
    chk_wait = 1'b0; wait_seen = 1'b0;
    m_vld = 2'b00; m_waddr = '0; m_lo = '0; m_hi = '0; m_sum = '0;
    reset = 1'b1; ioctl_download = 1'b0; ioctl_index = 8'd0;
    ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;

    // reset state
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_wait", 64'(ioctl_wait), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_checksum", 64'(checksum), 64'd0);
    check("rst_head", 64'({mem_region, mem_addr, mem_data}), 64'd0);

    // sequential 4-byte load
    ack_mode = ACK_NEXT;
    start_download();
    send_byte(25'd0, 8'h11, 1'b0);
    send_byte(25'd1, 8'h22, 1'b0);
    send_byte(25'd2, 8'h33, 1'b0);
    send_byte(25'd3, 8'h44, 1'b0);
    end_download();
    check("t1_count", 64'(got_q.size()), 64'd2);
    check("t1_w0", 64'(got_q[0]), 64'({2'd0, 24'd0, 16'h2211}));
    check("t1_w1", 64'(got_q[1]), 64'({2'd0, 24'd1, 16'h4433}));
`ifdef ROM_LOAD_CHECKSUM_EN
    check("t1_checksum", 64'(checksum), 64'h00AA);
`else
    check("t1_checksum", 64'(checksum), 64'h0000);
`endif

    // single odd byte in region 2, filled by flush
    start_download();
    send_byte(R2 + 25'd5, 8'h5A, 1'b0);
    end_download();
    check("t2_count", 64'(got_q.size()), 64'd1);
    check("t2_w0", 64'(got_q[0]), 64'({2'd2, 24'd2, 16'h5AFF}));

    // address jump evicts a half word, second half word flushed
    start_download();
    send_byte(25'h10, 8'h3C, 1'b0);
    send_byte(25'h20, 8'hC3, 1'b0);
    end_download();
    check("t3_count", 64'(got_q.size()), 64'd2);
    check("t3_w0", 64'(got_q[0]), 64'({2'd0, 24'h8, 16'hFF3C}));
    check("t3_w1", 64'(got_q[1]), 64'({2'd0, 24'h10, 16'hFFC3}));

    // memory stalled for 50 cycles while bytes stream
    ack_mode  = ACK_STALL;
    wait_seen = 1'b0;
    start_download();
    fork
      begin
        for (int i = 0; i < 12; i++) send_byte(25'h100 + 25'(i), 8'($urandom), 1'b0);
      end
      begin
        repeat (50) @(negedge clk_sys);
        ack_mode = ACK_NEXT;
      end
    join
    end_download();
    check("t4_wait_seen", 64'(wait_seen), 64'd1);
    check("t4_count", 64'(got_q.size()), 64'd6);
    check("t4_first_addr", 64'(got_q[0][39:16]), 64'h80);

    // non-zero index download is ignored
    d0 = done_seen;
    got_q.delete();
    @(negedge clk_sys);
    ioctl_index    = 8'd1;
    ioctl_download = 1'b1;
    for (int i = 0; i < 16; i++) send_byte(25'(i), 8'($urandom), 1'b0);
    @(negedge clk_sys);
    ioctl_download = 1'b0;
    repeat (5) @(negedge clk_sys);
    ioctl_index = 8'd0;
    check("idx1_no_done", 64'(done_seen - d0), 64'd0);
    check("idx1_no_write", 64'(got_q.size()), 64'd0);
    check("idx1_busy", 64'(busy), 64'd0);
    check("idx1_checksum", 64'(checksum), 64'(exp_checksum()));

    // reset in the middle of draining three queued words
    ack_mode = ACK_STALL;
    start_download();
    send_byte(25'd0, 8'hA0, 1'b0);
    send_byte(25'd1, 8'hA1, 1'b0);
    send_byte(25'd2, 8'hA2, 1'b0);
    send_byte(25'd3, 8'hA3, 1'b0);
    send_byte(25'd4, 8'hA4, 1'b1);
    @(negedge clk_sys);
    ioctl_download = 1'b0;
    chk_wait       = 1'b0;
    @(negedge clk_sys);
    model_flush();
    repeat (3) @(negedge clk_sys);
    check("t5_queued", 64'(exp_q.size()), 64'd3);
    check("t5_busy_before", 64'(busy), 64'd1);
    d0 = done_seen;
    @(negedge clk_sys);
    reset = 1'b1;
    exp_q.delete();
    m_vld = 2'b00;
    m_sum = 16'h0000;
    @(posedge clk_sys);
    #1;
    check("t5_req_after_rst", 64'(mem_req), 64'd0);
    check("t5_busy_after_rst", 64'(busy), 64'd0);
    @(negedge clk_sys);
    reset    = 1'b0;
    ack_mode = ACK_LATE;
    repeat (6) @(negedge clk_sys);
    check("t5_no_done", 64'(done_seen - d0), 64'd0);
    check("t5_req_idle", 64'(mem_req), 64'd0);
    check("t5_busy_idle", 64'(busy), 64'd0);

    // randomized loads around the region boundaries
    for (int l = 0; l < 10; l++) begin
      ack_mode = ($urandom_range(0, 1) == 0) ? ACK_NEXT : ACK_RAND;
      start_download();
      a = pick_addr();
      for (int b = 0; b < int'($urandom_range(1, 24)); b++) begin
        if ($urandom_range(0, 4) == 0) a = pick_addr();
        send_byte(a, 8'($urandom), 1'b0);
        a = a + 25'd1;
      end
      end_download();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // overall time bound
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
